aes_out_serializer: RTL and testbench
=====================================

AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 1: 1 = byte 0 is cipher_in[127:120]; 0 = byte 0 is cipher_in[7:0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cipher_in  input  128  completed cipher block from the AES round datapath.
REQ-005 cipher_valid  input  1  cipher_in holds a block for transfer.
REQ-006 cipher_ready  output  1  block accepted on a cycle where cipher_valid && cipher_ready.
REQ-007 byte_out  output  8  current output byte.
REQ-008 byte_valid  output  1  byte_out holds a valid byte.
REQ-009 byte_ready  input  1  downstream accepts; a byte transfers on a cycle where byte_valid && byte_ready.
REQ-010 byte_last  output  1  high with byte_valid on byte index 15 of a block.
REQ-011 byte_idx  output  4  index (0-15) of the byte on byte_out.
REQ-012 blk_cnt  output  8  count of fully transferred blocks.

Function
REQ-013 State machine SHALL have exactly two states: IDLE (shift register empty) and SEND (shift register holds a block).
REQ-014 Storage SHALL be one 128-bit shift register plus one 128-bit pending register with a pend_full flag.
REQ-015 cipher_ready SHALL equal !pend_full, combinationally, in both states.
REQ-016 In IDLE, an accepted block SHALL load into the shift register; next cycle is SEND with byte_valid=1, byte_idx=0 (latency 1 cycle).
REQ-017 In SEND, an accepted block SHALL load into the pending register and set pend_full.
REQ-018 byte_valid SHALL be 1 in SEND and 0 in IDLE.
REQ-019 byte_out, byte_idx and byte_last SHALL hold stable while byte_valid && !byte_ready.
REQ-020 On each byte transfer with byte_idx<15, the shift register SHALL advance one byte and byte_idx SHALL increment by 1.
REQ-021 On a transfer with byte_idx=15:
- blk_cnt SHALL increment, wrapping 255->0.
- byte_idx SHALL return to 0.
REQ-022 Last-byte transfer with pend_full=1: the pending block SHALL move to the shift register and pend_full SHALL clear; state stays SEND with no bubble cycle.
REQ-023 Last-byte transfer with pend_full=0 and no block accepted that cycle: the next state SHALL be IDLE.
REQ-024 Last-byte transfer with pend_full=0 and a block accepted in the same cycle: the block SHALL load directly into the shift register (bypass), state stays SEND, and pend_full stays 0.
REQ-025 Last-byte transfer with pend_full=1 and cipher_valid=1: no acceptance occurs that cycle, since cipher_ready=0.
REQ-026 byte_last SHALL be 1 only when byte_valid=1 and byte_idx=15.
REQ-027 cipher_in SHALL be sampled only on an accepting cycle; later changes SHALL NOT affect bytes already captured.
REQ-028 Byte order per block SHALL follow MSB_FIRST (REQ-001) for all 16 bytes.

Reset
REQ-029 Asserting rst SHALL immediately force:
- state IDLE, pend_full=0;
- byte_out=0, byte_valid=0, byte_last=0, byte_idx=0, blk_cnt=0;
- shift and pending registers cleared.
REQ-030 rst asserted mid-block SHALL discard partially sent and pending blocks; no byte of them SHALL appear after reset release.
REQ-031 After rst deasserts, cipher_ready SHALL be 1 and the first rising edge SHALL be able to accept a block.

Verification
REQ-032 Single block: MSB_FIRST=1, cipher_in=0x69c4e0d86a7b0430d8cdb78070b4c55a, byte_ready=1 -> bytes 69,c4,e0,...,c5,5a on 16 consecutive cycles starting 1 cycle after accept; byte_last on 5a; blk_cnt=1; then IDLE.
REQ-033 Backpressure: as REQ-032, but byte_ready=0 for 3 cycles at byte_idx=4 -> byte_out=0x6a held for those cycles; sequence otherwise unchanged.
REQ-034 Back-to-back blocks: second block offered during byte 2 of the first -> cipher_ready drops to 0; second block's byte 0 follows first block's byte 15 with no gap; blk_cnt=2.
REQ-035 Bypass: second block offered exactly on the first block's last-byte transfer with pend_full=0 -> accepted that cycle; byte 0 appears on the next cycle; pend_full stays 0.
REQ-036 Reset mid-block: rst pulsed at byte_idx=7 with a pending block held -> all outputs 0 and cipher_ready=1 immediately; no stale bytes after release.
REQ-037 MSB_FIRST=0 with the REQ-032 block -> first byte 0x5a, last byte 0x69.

Source files
------------

// File: rtl/aes_out_serializer.sv
// Serializes 128-bit AES cipher blocks into a byte stream with valid/ready
// handshakes on both sides. One block is shifted out while a second can wait
// in a pending register, so back-to-back blocks stream without a bubble.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   cipher_in     : 128-bit block from the round datapath
//   cipher_valid  : cipher_in holds a block
//   cipher_ready  : block accepted when cipher_valid && cipher_ready
//   byte_out      : current output byte
//   byte_valid    : byte_out holds a valid byte
//   byte_ready    : downstream accepts the byte
//   byte_last     : marks byte index 15 of a block
//   byte_idx      : index of the byte on byte_out
//   blk_cnt       : number of fully transferred blocks (wraps)
module aes_out_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] cipher_in,
  input  logic         cipher_valid,
  output logic         cipher_ready,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         byte_last,
  output logic [3:0]   byte_idx,
  output logic [7:0]   blk_cnt
);

  localparam int unsigned BLK_W   = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   shift_q, shift_d;
  logic [BLK_W-1:0]   pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  logic               accept;
  logic               xfer;
  logic               last_xfer;
  logic [BLK_W-1:0]   shift_adv;

  // Handshake qualifiers
  assign accept    = cipher_valid && !pend_full_q;
  assign xfer      = (state_q == SEND) && byte_ready;
  assign last_xfer = xfer && (idx_q == LAST_IDX);

  // Shift register moves the next byte into the output position
  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_adv = {shift_q[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
      assign byte_out  = shift_q[BLK_W-1 -: BYTE_W];
    end else begin : g_lsb
      assign shift_adv = {BYTE_W'(0), shift_q[BLK_W-1:BYTE_W]};
      assign byte_out  = shift_q[BYTE_W-1:0];
    end
  endgenerate

  // All outputs are decoded straight from state registers
  assign cipher_ready = !pend_full_q;
  assign byte_valid   = (state_q == SEND);
  assign byte_last    = (state_q == SEND) && (idx_q == LAST_IDX);
  assign byte_idx     = idx_q;
  assign blk_cnt      = blk_cnt_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      blk_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      blk_cnt_q   <= blk_cnt_d;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    blk_cnt_d   = blk_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = cipher_in;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (last_xfer) begin
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          idx_d     = '0;
          if (pend_full_q) begin
            // Pending block follows immediately; no acceptance this cycle
            shift_d     = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            // Bypass: new block goes straight into the shift register
            shift_d = cipher_in;
          end else begin
            shift_d = shift_adv;
            state_d = IDLE;
          end
        end else begin
          if (xfer) begin
            shift_d = shift_adv;
            idx_d   = idx_q + IDX_W'(1);
          end
          if (accept) begin
            pend_d      = cipher_in;
            pend_full_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer: two instances (MSB-first and
// LSB-first) share stimulus; accepted blocks are expanded into expected byte
// sequences and a negedge monitor compares every visible output.
module tb_aes_out_serializer;

  localparam logic [127:0] VEC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] cipher_in;
  logic         cipher_valid;
  logic         byte_ready;

  logic         cr_m, bv_m, bl_m, cr_l, bv_l, bl_l;
  logic [7:0]   bo_m, bc_m, bo_l, bc_l;
  logic [3:0]   bi_m, bi_l;

  always #5 clk = ~clk;

  aes_out_serializer #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .cipher_in(cipher_in), .cipher_valid(cipher_valid),
    .cipher_ready(cr_m), .byte_out(bo_m), .byte_valid(bv_m),
    .byte_ready(byte_ready), .byte_last(bl_m), .byte_idx(bi_m), .blk_cnt(bc_m)
  );

  aes_out_serializer #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .cipher_in(cipher_in), .cipher_valid(cipher_valid),
    .cipher_ready(cr_l), .byte_out(bo_l), .byte_valid(bv_l),
    .byte_ready(byte_ready), .byte_last(bl_l), .byte_idx(bi_l), .blk_cnt(bc_l)
  );

  typedef struct {
    logic [7:0] bm;
    logic [7:0] bl;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   blk_model = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_out_m"},   32'(bo_m), 32'd0);
    chk({nm, "_out_l"},   32'(bo_l), 32'd0);
    chk({nm, "_valid_m"}, 32'(bv_m), 32'd0);
    chk({nm, "_valid_l"}, 32'(bv_l), 32'd0);
    chk({nm, "_last_m"},  32'(bl_m), 32'd0);
    chk({nm, "_idx_m"},   32'(bi_m), 32'd0);
    chk({nm, "_cnt_m"},   32'(bc_m), 32'd0);
    chk({nm, "_cnt_l"},   32'(bc_l), 32'd0);
    chk({nm, "_ready_m"}, 32'(cr_m), 32'd1);
    chk({nm, "_ready_l"}, 32'(cr_l), 32'd1);
  endtask

  // Monitor / reference model: outputs are checked against the model's view
  // of the current cycle, then the model applies the handshakes of the coming edge.
  always @(negedge clk) begin
    int   infl;
    logic ev;
    exp_t e;
    if (rst) begin
      q.delete();
      blk_model = 0;
      chk_reset_state("in_reset");
    end else begin
      ev   = (q.size() != 0);
      infl = (q.size() + 15) / 16;
      chk("valid_m", 32'(bv_m), 32'(ev));
      chk("valid_l", 32'(bv_l), 32'(ev));
      chk("ready_m", 32'(cr_m), 32'(infl < 2));
      chk("ready_l", 32'(cr_l), 32'(infl < 2));
      chk("blkcnt_m", 32'(bc_m), 32'(blk_model % 256));
      chk("blkcnt_l", 32'(bc_l), 32'(blk_model % 256));
      if (ev) begin
        chk("byte_m", 32'(bo_m), 32'(q[0].bm));
        chk("byte_l", 32'(bo_l), 32'(q[0].bl));
        chk("idx_m",  32'(bi_m), 32'(q[0].idx));
        chk("idx_l",  32'(bi_l), 32'(q[0].idx));
        chk("last_m", 32'(bl_m), 32'(q[0].idx == 15));
        chk("last_l", 32'(bl_l), 32'(q[0].idx == 15));
      end else begin
        chk("last_idle_m", 32'(bl_m), 32'd0);
      end
      if (ev && byte_ready) begin
        if (q[0].idx == 15) blk_model++;
        void'(q.pop_front());
      end
      if (cipher_valid && infl < 2) begin
        for (int k = 0; k < 16; k++) begin
          e.bm  = cipher_in[127 - 8*k -: 8];
          e.bl  = cipher_in[8*k +: 8];
          e.idx = k;
          q.push_back(e);
        end
      end
    end
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer a block until accepted; returns 1 ns after the accepting edge
  task automatic send_block(input logic [127:0] b);
    logic acc;
    int   n;
    cipher_in    = b;
    cipher_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = cr_m;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: block never accepted, got 0 required 1");
    end
    cipher_valid = 1'b0;
    cipher_in    = rand128();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: %0d bytes outstanding, required 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    cipher_valid = 1'b0;
    #1;
    chk_reset_state("rst_immediate");
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    cipher_valid = 1'b0;
    cipher_in    = '0;
    byte_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single block, both byte orders
    send_block(VEC);
    chk("single_first_m", 32'(bo_m), 32'h69);
    chk("single_first_l", 32'(bo_l), 32'h5a);
    wait_idle();
    chk("single_cnt", 32'(bc_m), 32'd1);

    // Backpressure at byte index 4
    send_block(VEC);
    repeat (4) @(posedge clk);
    #1;
    byte_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_m", 32'(bo_m), 32'h6a);
      chk("bp_hold_l", 32'(bo_l), 32'h80);
      chk("bp_idx",    32'(bi_m), 32'd4);
      @(posedge clk);
      #1;
    end
    byte_ready = 1'b1;
    wait_idle();

    // Back-to-back: second block offered during byte 2
    send_block(rand128());
    repeat (2) @(posedge clk);
    #1;
    send_block(rand128());
    chk("b2b_ready_drop", 32'(cr_m), 32'd0);
    wait_idle();
    chk("b2b_cnt", 32'(bc_m), 32'd4);

    // Bypass on the last-byte transfer
    send_block(rand128());
    repeat (15) @(posedge clk);
    #1;
    chk("bypass_at_last", 32'(bl_m), 32'd1);
    send_block(rand128());
    chk("bypass_idx0",  32'(bi_m), 32'd0);
    chk("bypass_valid", 32'(bv_m), 32'd1);
    chk("bypass_ready", 32'(cr_m), 32'd1);
    wait_idle();

    // Reset mid-block with a pending block held
    send_block(rand128());
    send_block(rand128());
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_idx",   32'(bi_m), 32'd7);
    chk("pre_rst_ready", 32'(cr_m), 32'd0);
    do_reset();
    send_block(rand128());
    wait_idle();

    // Random traffic with random backpressure and churning cipher_in
    for (int i = 0; i < 600; i++) begin
      byte_ready   = ($urandom_range(0, 3) != 0);
      cipher_valid = ($urandom_range(0, 2) == 0);
      cipher_in    = rand128();
      @(posedge clk);
      #1;
    end
    cipher_valid = 1'b0;
    byte_ready   = 1'b1;
    wait_idle();

    // Continuous streaming long enough to wrap blk_cnt
    cipher_valid = 1'b1;
    for (int i = 0; i < 4400; i++) begin
      cipher_in  = rand128();
      byte_ready = ($urandom_range(0, 15) != 0);
      @(posedge clk);
      #1;
    end
    cipher_valid = 1'b0;
    byte_ready   = 1'b1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
